// File: rtl/log_slave_pkg.sv
// Shared types and constants for the log write slave.
package log_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } log_slave_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/log_slave_ram.sv
// Simple dual-port buffer: byte-enabled write port, registered read-first read port.
module log_slave_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; a same-cycle write to the same word returns the old value.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/log_axi_write_slave.sv
// AXI4 write-only responder that logs write bursts into a local buffer.
//
// Handshake rule on every channel (AW, W, B): a transfer happens on the rising
// clock edge where both VALID and READY are high. The slave's READY/VALID
// outputs are registered and never depend combinationally on master inputs;
// once BVALID is raised it and BRESP stay constant until BREADY is seen.
module log_axi_write_slave
  import log_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR_I,
  input  logic [7:0]                   S_AXI_AWLEN_I,
  input  logic [2:0]                   S_AXI_AWSIZE_I,
  input  logic [1:0]                   S_AXI_AWBURST_I,
  input  logic                         S_AXI_AWVALID_I,
  output logic                         S_AXI_AWREADY_O,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA_I,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB_I,
  input  logic                         S_AXI_WLAST_I,
  input  logic                         S_AXI_WVALID_I,
  output logic                         S_AXI_WREADY_O,
  output logic [1:0]                   S_AXI_BRESP_O,
  output logic                         S_AXI_BVALID_O,
  input  logic                         S_AXI_BREADY_I,
  input  logic [$clog2(DEPTH)-1:0]     RD_ADDR_I,
  output logic [DATA_WIDTH-1:0]        RD_DATA_O,
  output logic                         BURST_DONE_O,
  output logic [31:0]                  BEAT_COUNT_O,
  output logic                         ERROR_O,
  input  logic                         CLR_I,
  output log_slave_state_t             DBG_STATE_O
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  log_slave_state_t      state;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  burst_done_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            len_q;
  logic                  incr_q;
  logic                  err_q;
  logic [8:0]            beat_idx;
  logic [31:0]           beat_count_q;
  logic                  error_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_full;
  logic                  in_range;
  logic                  w_hs;
  logic                  b_hs;
  logic                  beyond_len;
  logic                  last_bad;
  logic                  store;
  logic                  err_next;

  // Beat decode: buffer word for the current address and whether the beat may be stored.
  always_comb begin
    offset     = cur_addr - BASE_ADDR;
    word_full  = offset >> SHIFT;
    in_range   = (cur_addr >= BASE_ADDR) && (word_full < ADDR_WIDTH'(DEPTH));
    w_hs       = wready_q && S_AXI_WVALID_I;
    b_hs       = bvalid_q && S_AXI_BREADY_I;
    beyond_len = beat_idx > {1'b0, len_q};
    last_bad   = S_AXI_WLAST_I && (beat_idx != {1'b0, len_q});
    store      = w_hs && !err_q && in_range && !beyond_len;
    err_next   = err_q || (w_hs && (!in_range || beyond_len || last_bad));
  end

  // Burst FSM with registered channel handshake outputs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state        <= ST_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      burst_done_q <= 1'b0;
      cur_addr     <= '0;
      len_q        <= '0;
      incr_q       <= 1'b0;
      err_q        <= 1'b0;
      beat_idx     <= '0;
    end else begin
      burst_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && S_AXI_AWVALID_I) begin
            cur_addr  <= S_AXI_AWADDR_I;
            len_q     <= S_AXI_AWLEN_I;
            incr_q    <= (S_AXI_AWBURST_I == BURST_INCR);
            err_q     <= (S_AXI_AWSIZE_I != 3'(SHIFT)) || S_AXI_AWBURST_I[1];
            beat_idx  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            err_q <= err_next;
            // Saturate so an overlong burst keeps reading as beyond AWLEN.
            if (beat_idx != '1) begin
              beat_idx <= beat_idx + 9'd1;
            end
            if (incr_q) begin
              cur_addr <= cur_addr + ADDR_WIDTH'(NB);
            end
            if (S_AXI_WLAST_I) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= err_next ? RESP_SLVERR : RESP_OKAY;
              state    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            awready_q    <= 1'b1;
            burst_done_q <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Running status: stored-beat counter and sticky error; a clear overrides same-cycle events.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      beat_count_q <= '0;
      error_q      <= 1'b0;
    end else if (CLR_I) begin
      beat_count_q <= '0;
      error_q      <= 1'b0;
    end else begin
      if (store && (beat_count_q != '1)) begin
        beat_count_q <= beat_count_q + 32'd1;
      end
      if (b_hs && err_q) begin
        error_q <= 1'b1;
      end
    end
  end

  log_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .wr_en   (store),
    .wr_be   (S_AXI_WSTRB_I),
    .wr_addr (word_full[IDX_W-1:0]),
    .wr_data (S_AXI_WDATA_I),
    .rd_addr (RD_ADDR_I),
    .rd_data (RD_DATA_O)
  );

  assign S_AXI_AWREADY_O = awready_q;
  assign S_AXI_WREADY_O  = wready_q;
  assign S_AXI_BVALID_O  = bvalid_q;
  assign S_AXI_BRESP_O   = bresp_q;
  assign BURST_DONE_O    = burst_done_q;
  assign BEAT_COUNT_O    = beat_count_q;
  assign ERROR_O         = error_q;
  assign DBG_STATE_O     = state;

endmodule
